// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default bus widths, client bundles
// and the wait-counter sizing helper.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

  // Counter must reach TIMEOUT; a disabled timeout still needs a 1-bit counter.
  function automatic int wait_cnt_w(input int timeout);
    if (timeout < 1) begin
      return 1;
    end else begin
      return $clog2(timeout + 1);
    end
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS wait-state counter; expired flags count == TIMEOUT.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = wait_cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count_r;

  // Wait counter: clear wins over enable, and it holds at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      count_r <= {CNT_W{1'b0}};
    end else if (en && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end
  end

  assign expired = (count_r == LIMIT);

endmodule

// File: rtl/apb_master.sv
// APB initiator: one client request at a time through SETUP/ACCESS, with
// wait-state timeout, returning read data and error status to the client.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  localparam logic TIMEOUT_EN = (TIMEOUT != 0);

  logic [1:0] state_r;
  logic [1:0] next_state;
  logic       timer_clr;
  logic       timer_en;
  logic       expired;

  apb_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (PCLK),
    .rst    (PRESET),
    .clr    (timer_clr),
    .en     (timer_en),
    .expired(expired)
  );

  // Next-state and wait-timer control; PREADY takes priority over the timeout.
  always_comb begin
    next_state = state_r;
    timer_clr  = 1'b0;
    timer_en   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          next_state = ST_SETUP;
          timer_clr  = 1'b1;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_SETUP: begin
        next_state = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          next_state = ST_RESP;
        end else if (TIMEOUT_EN && expired) begin
          next_state = ST_RESP;
        end else begin
          next_state = ST_ACCESS;
          timer_en   = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          next_state = ST_IDLE;
        end else begin
          next_state = ST_RESP;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // State, APB bus and response registers; bus fields hold until the next capture.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_r   <= ST_IDLE;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= {ADDR_W{1'b0}};
      PWDATA    <= {DATA_W{1'b0}};
      rsp_rdata <= {DATA_W{1'b0}};
      rsp_err   <= 1'b0;
    end else begin
      state_r <= next_state;
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            PSEL   <= 1'b1;
            PWRITE <= cmd_write;
            PADDR  <= cmd_addr;
            if (cmd_write) begin
              PWDATA <= cmd_wdata;
            end
          end
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
        end
        ST_ACCESS: begin
          if (next_state == ST_RESP) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            if (PREADY) begin
              rsp_err   <= 1'b0;
              rsp_rdata <= PWRITE ? {DATA_W{1'b0}} : PRDATA;
            end else begin
              rsp_err   <= 1'b1;
              rsp_rdata <= {DATA_W{1'b0}};
            end
          end
        end
        ST_RESP: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
        end
        default: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = (state_r == ST_IDLE);
  assign rsp_valid = (state_r == ST_RESP);

endmodule

// File: doc/apb_master.md
# apb_master

APB initiator that converts single requests from a local client into APB transfers: SETUP phase, then ACCESS phase, with wait-state handling and a wait-state timeout. It drives the PSEL/PENABLE/PWRITE/PADDR/PWDATA bus seen by APB responders and returns read data and completion status to the client. It handles one transfer at a time, with a single PSEL and no address decoding.

## Interface
- ADDR_W, 32, width of PADDR and cmd_addr
- DATA_W, 32, width of PWDATA, PRDATA, cmd_wdata and rsp_rdata
- TIMEOUT, 16, maximum wait cycles (PREADY low) in ACCESS before abort; 0 disables the timeout
- PCLK  in  1  APB clock; all logic is on the rising edge
- PRESET  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  client request valid
- cmd_ready  out  1  master can accept a request; equals (state == IDLE)
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  client accepts the response
- rsp_rdata  out  DATA_W  read data; 0 for writes and for timed-out transfers
- rsp_err  out  1  1 = transfer aborted by timeout
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB ready

## Operation
- State machine states: IDLE, SETUP, ACCESS, RESP. The reset state is IDLE.
- IDLE:
  - Handshake: cmd_valid & cmd_ready.
  - On handshake, capture write/addr/wdata into PWRITE/PADDR/PWDATA, then go to SETUP.
  - cmd_valid is ignored while PRESET is high.
- SETUP: PSEL=1, PENABLE=0. Always goes to ACCESS on the next cycle.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY=1: the transfer completes. If it is a read, latch PRDATA into rsp_rdata. Set rsp_err=0 and go to RESP.
  - PREADY=0: increment the wait counter.
  - Timeout: TIMEOUT≠0 and the counter equals TIMEOUT with PREADY still 0. Set rsp_err=1, rsp_rdata=0 and go to RESP.
  - PREADY on the same edge as the timeout: PREADY wins and the transfer completes normally.
- RESP: PSEL=0, PENABLE=0, rsp_valid=1. On rsp_ready go to IDLE; otherwise hold.
- Bus stability:
  - PADDR, PWRITE and PWDATA stay constant from SETUP through the last ACCESS cycle.
  - After the transfer they hold their values until the next capture; no return to 0.
- Read responses: PWDATA is not updated; it holds its previous value.
- Wait counter:
  - Width is $clog2(TIMEOUT+1), minimum 1.
  - Cleared on entry to SETUP.
  - Saturates; it never wraps.
- Reset (asserted at any time, including mid-transfer):
  - State goes to IDLE immediately (asynchronous).
  - All outputs take their reset values.
  - The in-flight transfer is dropped and no response is produced.

## Timing
- Reset values:
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - cmd_ready=1, because state is IDLE.
- All APB outputs and rsp_* outputs are registered. cmd_ready and rsp_valid are decoded from the state register, with no input-to-output combinational path.
- Latency from the cmd handshake edge:
  - PSEL rises 1 cycle later.
  - PENABLE rises 2 cycles later.
  - With zero waits, rsp_valid rises 3 cycles later.
  - Each PREADY-low cycle adds 1 cycle.
- Back-to-back transfers with rsp_ready tied high: one transfer per 4 cycles (IDLE, SETUP, ACCESS, RESP).
- Timeout: with PREADY stuck low, rsp_valid with rsp_err=1 rises TIMEOUT+3 cycles after the handshake. PSEL stays high for exactly TIMEOUT+2 cycles.
- PSEL and PENABLE deassert together on the edge that leaves ACCESS.

## Structure
- Shared package apb_pkg holds:
  - the state encoding (IDLE=0, SETUP=1, ACCESS=2, RESP=3);
  - default ADDR_W and DATA_W;
  - the apb_cmd_t and apb_rsp_t bundle typedefs, shared with the responder side.
- One sub-module is natural: apb_wait_timer. It is a saturating counter with clear, enable, and an expired output for count == TIMEOUT.
- The FSM and bus registers stay in apb_master.

## Test plan
- Write, zero wait, TIMEOUT=16:
  - Stimulus: cmd addr=0x4, wdata=0xDEADBEEF, PREADY=1.
  - Required: PSEL at +1, PENABLE at +2, PADDR=0x4 and PWDATA=0xDEADBEEF stable over both phases, rsp_valid at +3 with rsp_err=0.
- Read with 3 wait states:
  - Stimulus: responder model drives PREADY=0 for 3 ACCESS cycles, then PRDATA=0x12345678 with PREADY=1.
  - Required: rsp_valid at +6, rsp_rdata=0x12345678, PENABLE high for 4 cycles.
- Timeout with TIMEOUT=4 and PREADY stuck 0:
  - Required: PSEL high for 6 cycles, then rsp_valid with rsp_err=1 and rsp_rdata=0.
- PREADY asserted on the timeout edge:
  - Required: rsp_err=0 and read data captured.
- Response backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles.
  - Required: rsp_valid and rsp_rdata held; cmd_ready=0 and PSEL=0 throughout; IDLE on the first rsp_ready=1.
- Reset mid-transfer:
  - Stimulus: assert PRESET during ACCESS with PREADY=0.
  - Required: PSEL, PENABLE and rsp_valid fall within the same cycle with no clock edge; after release, cmd_ready=1 and the next write completes normally.
